// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes, scheduler states and shared widths.
package alu_pkg;
    localparam int ALU_RES_W = 16;
    localparam int ALU_OP_W  = 4;
    typedef enum logic [ALU_OP_W-1:0] {ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, DIV = 4'd3, AND = 4'd4, XOR = 4'd5} alu_op_e;
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} sched_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  id
);
    int w_idx;
    // Scan from the farthest position back to ptr so the closest hit wins.
    always_comb begin
        grant = '0;
        id    = '0;
        w_idx = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = (int'(ptr) + k) % N_REQ;
            if (req[w_idx]) begin
                grant        = '0;
                grant[w_idx] = 1'b1;
                id           = ID_W'(w_idx);
            end
        end
    end
endmodule

// File: rtl/alu_req_scheduler.sv
// alu_req_scheduler: round-robin sharing of one registered ALU among N_REQ requesters.
// Define ALU_DIV0_GUARD_EN to reject DIV by zero before it reaches the ALU.
module alu_req_scheduler
    import alu_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*8-1:0]   req_a,
    input  logic [N_REQ*8-1:0]   req_b,
    input  logic [N_REQ*4-1:0]   req_op,
    input  logic [N_REQ-1:0]     req_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [ALU_RES_W-1:0] rsp_result,
    output logic                 rsp_c_out,
    output logic                 rsp_z,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 alu_rst_n,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic                 alu_c_in,
    input  logic [ALU_RES_W-1:0] alu_result,
    input  logic                 alu_c_out,
    input  logic                 alu_z_flag
);
    sched_state_e         r_state;
    logic [ID_W-1:0]      r_ptr, r_id, w_id;
    logic [N_REQ-1:0]     w_grant;
    logic [7:0]           r_alu_a, r_alu_b, w_a, w_b;
    logic [ALU_OP_W-1:0]  r_alu_op, w_op;
    logic                 r_alu_cin, w_cin, w_div0;
    logic [ALU_RES_W-1:0] r_result;
    logic                 r_c, r_z, r_err;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req(req_valid), .ptr(r_ptr), .grant(w_grant), .id(w_id)
    );

    always_comb begin
        w_a   = '0;
        w_b   = '0;
        w_op  = '0;
        w_cin = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_a   = req_a[8*i +: 8];
                w_b   = req_b[8*i +: 8];
                w_op  = req_op[4*i +: 4];
                w_cin = req_cin[i];
            end
        end
    end

`ifdef ALU_DIV0_GUARD_EN
    assign w_div0 = (w_op == DIV) && (w_b == 8'd0);
`else
    assign w_div0 = 1'b0;
`endif

    // Grant is visible only while IDLE and out of reset, so every output is 0 during rst.
    assign req_ready  = (r_state == IDLE && !rst) ? w_grant : '0;
    assign rsp_valid  = (r_state == RESP);
    assign busy       = (r_state != IDLE);
    assign rsp_id     = r_id;
    assign rsp_result = r_result;
    assign rsp_c_out  = r_c;
    assign rsp_z      = r_z;
    assign rsp_err    = r_err;
    assign alu_rst_n  = ~rst;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign alu_c_in   = r_alu_cin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_id      <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= '0;
            r_alu_cin <= 1'b0;
            r_result  <= '0;
            r_c       <= 1'b0;
            r_z       <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (|req_valid) begin
                    r_id  <= w_id;
                    r_ptr <= (w_id == ID_W'(N_REQ - 1)) ? '0 : w_id + 1'b1;
                    // Rejected ops bypass the ALU so its operand registers stay untouched.
                    if (w_op > ALU_OP_W'(XOR) || w_div0) begin
                        r_state  <= RESP;
                        r_err    <= 1'b1;
                        r_result <= w_div0 ? '1 : '0;
                        r_c      <= 1'b0;
                        r_z      <= 1'b0;
                    end else begin
                        r_state   <= ISSUE;
                        r_alu_a   <= w_a;
                        r_alu_b   <= w_b;
                        r_alu_op  <= w_op;
                        r_alu_cin <= w_cin;
                    end
                end
                ISSUE: r_state <= CAPTURE;
                CAPTURE: begin
                    r_state  <= RESP;
                    r_result <= alu_result;
                    r_c      <= alu_c_out;
                    r_z      <= alu_z_flag;
                    r_err    <= 1'b0;
                end
                RESP: if (rsp_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_req_scheduler.sv
// tb_alu_req_scheduler: randomized and directed checks of alu_req_scheduler against a
// request-level model; a behavioural registered ALU closes the loop.
module tb_alu_req_scheduler;
    logic        clk = 0;
    logic        rst;
    logic [3:0]  req_valid, req_ready, req_cin;
    logic [31:0] req_a, req_b;
    logic [15:0] req_op;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_result;
    logic        rsp_c_out, rsp_z, rsp_err, busy, alu_rst_n;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_op;
    logic        alu_c_in;
    logic [15:0] alu_result;
    logic        alu_c_out, alu_z_flag;

    int n_cmp = 0;
    int n_err = 0;
    int ref_ptr = 0;
    int last_w;
    logic [15:0] last_res;
    logic        last_c;
    logic [7:0]  t_a[4], t_b[4];
    logic [3:0]  t_op[4];
    logic        t_cin[4];

    alu_req_scheduler dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_c_out(rsp_c_out), .rsp_z(rsp_z), .rsp_err(rsp_err),
        .busy(busy), .alu_rst_n(alu_rst_n), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_c_in(alu_c_in), .alu_result(alu_result), .alu_c_out(alu_c_out), .alu_z_flag(alu_z_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op, input logic cin);
        logic [15:0] r;
        logic c;
        c = 1'b0;
        case (op)
            4'd0: begin r = 16'(a) + 16'(b) + 16'(cin); c = r[8]; end
            4'd1: begin r = 16'(a) - 16'(b); c = (a < b); end
            4'd2: r = 16'(a) * 16'(b);
            4'd3: r = (b == 8'd0) ? 16'hEEEE : 16'(a / b);
            4'd4: r = {8'h00, a & b};
            4'd5: r = {8'h00, a ^ b};
            default: r = 16'hDEAD;
        endcase
        return {c, r == 16'd0, r};
    endfunction

    always @(posedge clk or negedge alu_rst_n) begin
        if (!alu_rst_n) {alu_c_out, alu_z_flag, alu_result} <= '0;
        else {alu_c_out, alu_z_flag, alu_result} <= alu_f(alu_a, alu_b, alu_op, alu_c_in);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int rr_pick(input logic [3:0] mask, input int ptr);
        for (int k = 0; k < 4; k++)
            if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin,
                         output int lat, output logic [15:0] r, output logic c, output logic z, output logic e);
        if (op > 4'd5) begin
            lat = 1; r = 16'd0; c = 1'b0; z = 1'b0; e = 1'b1;
        end
`ifdef ALU_DIV0_GUARD_EN
        else if (op == 4'd3 && b == 8'd0) begin
            lat = 1; r = 16'hFFFF; c = 1'b0; z = 1'b0; e = 1'b1;
        end
`endif
        else begin
            lat = 3; {c, z, r} = alu_f(a, b, op, cin); e = 1'b0;
        end
    endtask

    task automatic drive_fields;
        for (int i = 0; i < 4; i++) begin
            req_a[8*i +: 8]  = t_a[i];
            req_b[8*i +: 8]  = t_b[i];
            req_op[4*i +: 4] = t_op[i];
            req_cin[i]       = t_cin[i];
        end
    endtask

    task automatic check_all_zero(input string name);
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_id, rsp_result, rsp_c_out, rsp_z, rsp_err, busy, alu_rst_n,
             alu_a, alu_b, alu_op, alu_c_in} !== '0) begin
            n_err++;
            $display("FAIL %s: outputs in reset rdy=%b v=%b id=%0d res=%h c=%b z=%b err=%b busy=%b rst_n=%b alu=%h/%h/%h/%b, want all 0",
                     name, req_ready, rsp_valid, rsp_id, rsp_result, rsp_c_out, rsp_z, rsp_err, busy, alu_rst_n,
                     alu_a, alu_b, alu_op, alu_c_in);
        end
    endtask

    task automatic apply_reset(input string name);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 4'hF;
        #1;
        check_all_zero(name);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'h0;
        ref_ptr = 0;
    endtask

    // One full command/response exchange; rsp_ready held low for `hold` cycles in RESP.
    task automatic transact(input logic [3:0] mask, input int hold, input string name);
        int w, lat, exp_lat;
        logic [15:0] er;
        logic ec, ez, ee;
        logic [20:0] snap_alu, exp_alu;
        logic [20:0] s_rsp;
        @(negedge clk);
        drive_fields();
        req_valid = mask;
        snap_alu = {alu_a, alu_b, alu_op, alu_c_in};
        #1;
        w = rr_pick(mask, ref_ptr);
        n_cmp++;
        if (req_ready !== 4'(1 << w)) begin
            n_err++;
            $display("FAIL %s grant: req_ready=%b want %b", name, req_ready, 4'(1 << w));
        end
        ref_ptr = (w + 1) % 4;
        last_w = w;
        model(t_op[w], t_a[w], t_b[w], t_cin[w], exp_lat, er, ec, ez, ee);
        @(negedge clk);
        req_valid = mask & ~(4'(1 << w));
        exp_alu = (exp_lat == 3) ? {t_a[w], t_b[w], t_op[w], t_cin[w]} : snap_alu;
        n_cmp++;
        if ({alu_a, alu_b, alu_op, alu_c_in} !== exp_alu) begin
            n_err++;
            $display("FAIL %s alu_inputs: got %h want %h", name, {alu_a, alu_b, alu_op, alu_c_in}, exp_alu);
        end
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat != exp_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if ({rsp_id, rsp_result, rsp_err} !== {2'(w), er, ee}) begin
            n_err++;
            $display("FAIL %s response: id=%0d res=%h err=%b want id=%0d res=%h err=%b",
                     name, rsp_id, rsp_result, rsp_err, w, er, ee);
        end
        if (t_op[w] <= 4'd5) begin
            n_cmp++;
            if ({rsp_c_out, rsp_z} !== {ec, ez}) begin
                n_err++;
                $display("FAIL %s flags: c=%b z=%b want c=%b z=%b", name, rsp_c_out, rsp_z, ec, ez);
            end
        end
        last_res = rsp_result;
        last_c = rsp_c_out;
        s_rsp = {rsp_id, rsp_result, rsp_c_out, rsp_z, rsp_err};
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({rsp_valid, busy, req_ready, rsp_id, rsp_result, rsp_c_out, rsp_z, rsp_err} !== {2'b11, 4'b0000, s_rsp}) begin
                n_err++;
                $display("FAIL %s hold: v=%b busy=%b rdy=%b rsp=%h want v=1 busy=1 rdy=0000 rsp=%h",
                         name, rsp_valid, busy, req_ready, {rsp_id, rsp_result, rsp_c_out, rsp_z, rsp_err}, s_rsp);
            end
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL %s release_grant: req_ready=%b want 0000", name, req_ready);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++;
        if ({busy, rsp_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL %s back_to_idle: busy=%b rsp_valid=%b want 0 0", name, busy, rsp_valid);
        end
        req_valid = 4'h0;
    endtask

    task automatic test_reset;
        apply_reset("reset");
    endtask

    task automatic test_single_add;
        t_a[0] = 8'hFF; t_b[0] = 8'h01; t_op[0] = 4'd0; t_cin[0] = 1'b1;
        transact(4'b0001, 0, "single_add");
        n_cmp++;
        if ({last_c, last_res} !== {1'b1, 16'h0101}) begin
            n_err++;
            $display("FAIL single_add literal: c=%b res=%h want c=1 res=0101", last_c, last_res);
        end
    endtask

    task automatic test_rr_order;
        apply_reset("rr_reset");
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) begin
                t_a[j] = 8'($urandom); t_b[j] = 8'($urandom); t_op[j] = 4'd4; t_cin[j] = 1'($urandom);
            end
            transact(4'hF, 0, "rr_order");
            n_cmp++;
            if (last_w != i % 4) begin
                n_err++;
                $display("FAIL rr_order step %0d: winner %0d want %0d", i, last_w, i % 4);
            end
        end
    endtask

    task automatic test_hold;
        for (int j = 0; j < 4; j++) begin
            t_a[j] = 8'($urandom); t_b[j] = 8'($urandom); t_op[j] = 4'd1; t_cin[j] = 1'b0;
        end
        transact(4'hF, 5, "hold");
    endtask

    task automatic test_illegal;
        t_a[2] = 8'h5A; t_b[2] = 8'hC3; t_op[2] = 4'h9; t_cin[2] = 1'b1;
        transact(4'b0100, 0, "illegal");
    endtask

    task automatic test_div0;
        t_a[1] = 8'h10; t_b[1] = 8'h00; t_op[1] = 4'd3; t_cin[1] = 1'b0;
        transact(4'b0010, 0, "div0");
    endtask

    task automatic test_rst_mid;
        t_a[2] = 8'h33; t_b[2] = 8'h05; t_op[2] = 4'd2; t_cin[2] = 1'b0;
        @(negedge clk);
        drive_fields();
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = 4'h0;
        @(negedge clk);
        n_cmp++;
        if ({busy, rsp_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL rst_mid capture: busy=%b rsp_valid=%b want 1 0", busy, rsp_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        ref_ptr = 0;
        for (int j = 0; j < 4; j++) begin
            t_a[j] = 8'($urandom); t_b[j] = 8'($urandom); t_op[j] = 4'd5; t_cin[j] = 1'b0;
        end
        transact(4'hF, 0, "post_rst");
        n_cmp++;
        if (last_w != 0) begin
            n_err++;
            $display("FAIL post_rst winner: got %0d want 0", last_w);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            for (int j = 0; j < 4; j++) begin
                t_a[j]   = 8'($urandom);
                t_b[j]   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                t_op[j]  = 4'($urandom_range(0, 7));
                t_cin[j] = 1'($urandom);
            end
            transact(4'($urandom_range(1, 15)), $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; req_op = '0; req_cin = '0; rsp_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            t_a[j] = '0; t_b[j] = '0; t_op[j] = '0; t_cin[j] = 1'b0;
        end
        test_reset();
        test_single_add();
        test_rr_order();
        test_hold();
        test_illegal();
        test_div0();
        test_rst_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
